// File: rtl/divider_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: FSM state encodings
// and the result-valid strobe levels.
package divider_pkg;

  // Divider control states (2-bit encoding shared with the hazard logic).
  typedef enum logic [1:0] {
    DivFree   = 2'd0,
    DivByZero = 2'd1,
    DivOn     = 2'd2,
    DivEnd    = 2'd3
  } div_state_e;

  // Levels of the one-cycle result-valid strobe.
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU in the execute stage.
// Iterates one quotient bit per cycle on operand magnitudes, fixes signs on
// the way into END, and presents {remainder, quotient} with a one-cycle
// ready strobe. stall is combinational so the DIV is held in E from the very
// cycle it is first seen. An exception flush (annul) abandons the operation.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 annul,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 stall
);

  localparam int CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};

  // State and datapath registers.
  div_state_e             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]       acc_q, acc_d;      // {remainder, quotient} shift register
  logic [WIDTH-1:0]       dvsr_q, dvsr_d;
  logic                   neg_quo_q, neg_quo_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]     result_q, result_d;
  logic                   ready_q, ready_d;
  logic                   stall_s;

  // Operand conditioning and restoring-step signals.
  logic                   a_neg_s, b_neg_s;
  logic [WIDTH-1:0]       a_mag_s, b_mag_s;
  logic [WIDTH:0]         hi_s, trial_s;
  logic                   fits_s;
  logic [2*WIDTH:0]       step_s;
  logic [WIDTH-1:0]       quo_s, rem_s, quo_fix_s, rem_fix_s;

  // Operand magnitudes and sign flags; only DIV treats the MSB as a sign.
  always_comb begin
    a_neg_s = signed_div & a[WIDTH-1];
    b_neg_s = signed_div & b[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = {WIDTH{1'b0}} - a;
    end else begin
      a_mag_s = a;
    end
    if (b_neg_s) begin
      b_mag_s = {WIDTH{1'b0}} - b;
    end else begin
      b_mag_s = b;
    end
  end

  // One restoring step: shift {rem, quo} left, subtract divisor when it fits,
  // and produce the sign-corrected result as it would look after this step.
  always_comb begin
    hi_s    = acc_q[2*WIDTH-1:WIDTH-1];
    trial_s = hi_s - {1'b0, dvsr_q};
    fits_s  = acc_q[2*WIDTH] | (hi_s >= {1'b0, dvsr_q});
    if (fits_s) begin
      step_s = {trial_s, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_s = {hi_s, acc_q[WIDTH-2:0], 1'b0};
    end
    quo_s = step_s[WIDTH-1:0];
    rem_s = step_s[2*WIDTH-1:WIDTH];
    // Magnitude of 0x80000000 negates back onto itself, giving the wrap case.
    if (neg_quo_q) begin
      quo_fix_s = {WIDTH{1'b0}} - quo_s;
    end else begin
      quo_fix_s = quo_s;
    end
    if (neg_rem_q) begin
      rem_fix_s = {WIDTH{1'b0}} - rem_s;
    end else begin
      rem_fix_s = rem_s;
    end
  end

  // Next-state, datapath update and stall request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = DivResultNotReady;
    stall_s   = 1'b0;
    case (state_q)
      DivFree: begin
        if (start && !annul) begin
          stall_s = 1'b1;
          if (b != {WIDTH{1'b0}}) begin
            state_d   = DivOn;
            cnt_d     = CntZero;
            acc_d     = {{(WIDTH+1){1'b0}}, a_mag_s};
            dvsr_d    = b_mag_s;
            neg_quo_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
          end else begin
            state_d = DivByZero;
          end
        end else begin
          state_d = DivFree;
        end
      end
      DivOn: begin
        stall_s = 1'b1;
        if (annul) begin
          state_d = DivFree;
        end else begin
          acc_d = step_s;
          cnt_d = cnt_q + CntOne;
          if (cnt_q == CntLast) begin
            state_d  = DivEnd;
            result_d = {rem_fix_s, quo_fix_s};
            ready_d  = DivResultReady;
          end else begin
            state_d = DivOn;
          end
        end
      end
      DivByZero: begin
        stall_s = 1'b1;
        if (annul) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = {(2*WIDTH){1'b0}};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        state_d = DivFree;
      end
      default: begin
        state_d = DivFree;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= CntZero;
      acc_q     <= {(2*WIDTH+1){1'b0}};
      dvsr_q    <= {WIDTH{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign stall  = stall_s;

endmodule
